// File: rtl/vol_pkg.sv
// Shared widths, display range and FSM encoding for the volume-level path.
package vol_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned LEVEL_W  = 4;
  localparam int unsigned LVL_MAX  = 15;

  typedef enum logic [1:0] {
    ACCUM,
    MAP,
    UPDATE
  } vol_state_t;

endpackage

// File: rtl/vol_map.sv
// Combinational peak -> raw display level: offset removal, shift, saturation.
module vol_map
  import vol_pkg::*;
#(
  parameter int unsigned OFFSET = 2048,
  parameter int unsigned SHIFT  = 7
) (
  input  logic [SAMPLE_W-1:0] peak,
  output logic [LEVEL_W-1:0]  raw
);

  logic [SAMPLE_W-1:0] diff;
  logic [SAMPLE_W-1:0] shifted;

  always_comb begin
    diff    = peak - SAMPLE_W'(OFFSET);
    shifted = diff >> SHIFT;
    raw     = '0;
    if (peak > SAMPLE_W'(OFFSET)) begin
      if (shifted > SAMPLE_W'(LVL_MAX)) raw = LEVEL_W'(LVL_MAX);
      else                              raw = shifted[LEVEL_W-1:0];
    end
  end

endmodule

// File: rtl/vol_level.sv
// Windowed peak detector driving the 0-15 volume bar level with instant rise,
// hold-then-decay fall and a display freeze.
module vol_level
  import vol_pkg::*;
#(
  parameter int unsigned WINDOW = 4000,
  parameter int unsigned OFFSET = 2048,
  parameter int unsigned SHIFT  = 7,
  parameter int unsigned HOLD   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                freeze,
  output logic [LEVEL_W-1:0]  num,
  output logic [SAMPLE_W-1:0] peak,
  output logic                level_valid
);

  localparam int unsigned CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] run_max;
  logic [SAMPLE_W-1:0] win_max;
  logic [SAMPLE_W-1:0] snap;
  logic [LEVEL_W-1:0]  raw;
  logic [LEVEL_W-1:0]  map_raw;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                close;
  vol_state_t          state;
  vol_state_t          state_nxt;

  always_comb begin
    win_max = (mic_in > run_max) ? mic_in : run_max;
    close   = sample_valid && (cnt == CNT_W'(WINDOW - 1));
  end

  // Accumulation is decoupled from the FSM so samples landing in MAP/UPDATE
  // already belong to the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_max <= '0;
      snap    <= '0;
    end else if (sample_valid) begin
      if (close) begin
        snap    <= win_max;
        run_max <= '0;
        cnt     <= '0;
      end else begin
        run_max <= win_max;
        cnt     <= cnt + CNT_W'(1);
      end
    end
  end

  vol_map #(
    .OFFSET (OFFSET),
    .SHIFT  (SHIFT)
  ) u_map (
    .peak (snap),
    .raw  (map_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ACCUM;
    case (state)
      ACCUM:   state_nxt = close ? MAP : ACCUM;
      MAP:     state_nxt = UPDATE;
      UPDATE:  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw         <= '0;
      num         <= '0;
      peak        <= '0;
      hold_cnt    <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      case (state)
        MAP: raw <= map_raw;
        UPDATE: begin
          peak        <= snap;
          level_valid <= 1'b1;
          if (!freeze) begin
            if (raw >= num) begin
              num      <= raw;
              hold_cnt <= HOLD_W'(HOLD);
            end else if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end else begin
              num <= num - LEVEL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vol_level.md
# vol_level

Producer side of the volume-bar display path. Takes the 12-bit microphone sample stream and closes a fixed window of samples. It converts each window's peak into the 0–15 `num` level that the bar renderer consumes. Rise is instantaneous, fall is limited by hold and decay, and a freeze input holds the displayed level.

## Interface
Parameters:
- `WINDOW`, 4000: accepted samples per window (≥1). At 20 kHz this gives a 5 Hz update rate.
- `OFFSET`, 2048: mic DC midpoint. A peak at or below it maps to level 0.
- `SHIFT`, 7: right-shift applied to `peak − OFFSET` to form the level.
- `HOLD`, 2: number of windows the level is held before decay starts.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sample_valid`, in, 1: one-cycle strobe; `mic_in` is valid in that cycle.
- `mic_in`, in, 12: unsigned mic sample.
- `freeze`, in, 1: when high in the UPDATE cycle, `num` and the hold counter are left unchanged.
- `num`, out, 4: displayed level 0–15. Feeds the bar renderer.
- `peak`, out, 12: raw peak of the last closed window.
- `level_valid`, out, 1: one-cycle pulse when `num`/`peak` are refreshed.

## Operation
- Reset values: `num`=0, `peak`=0, `level_valid`=0, `hold_cnt`=0, `cnt`=0, `run_max`=0, `snap`=0, `raw`=0, state=ACCUM. Asserting reset mid-window discards the partial window.
- Sample accumulation runs independently of the FSM and accepts `sample_valid` in every state:
  - `run_max` ← max(`run_max`, `mic_in`); `cnt` ← `cnt`+1.
  - On the closing sample (`cnt`==WINDOW−1): `snap` ← max(`run_max`, `mic_in`), `run_max` ← 0, `cnt` ← 0, start the FSM.
- FSM states: ACCUM → MAP → UPDATE → ACCUM.
  - ACCUM: idle until a window closes.
  - MAP: `raw` ← 0 if `snap` ≤ OFFSET, else min(15, (`snap`−OFFSET) >> SHIFT). Subtract at 12 bits, then saturate.
  - UPDATE:
    - `peak` ← `snap`; `level_valid` ← 1.
    - If `freeze`: `num`/`hold_cnt` unchanged.
    - Else if `raw` ≥ `num`: `num` ← `raw`, `hold_cnt` ← HOLD.
    - Else if `hold_cnt` > 0: `hold_cnt` ← `hold_cnt`−1.
    - Else `num` ← `num`−1.
- Decay is at most 1 step per window and never drops below `raw`.
- A `sample_valid` arriving during MAP or UPDATE is counted in the new window with no loss.
- Windows must close ≥3 cycles apart. This is guaranteed whenever WINDOW ≥ 3. For WINDOW < 3, sample spacing must be ≥3 cycles; closes spaced closer than that are unsupported.

## Timing
- Closing sample in cycle T:
  - MAP runs in T+1, UPDATE in T+2.
  - New `num`/`peak` are visible and `level_valid`=1 in cycle T+3 only.
- Latency from closing sample to output is 3 cycles. Throughput is one window per 3 cycles minimum.
- All outputs are registered. There are no combinational input-to-output paths.
- `freeze` is sampled only in the UPDATE cycle.

## Structure
- Shared package `vol_pkg` holds:
  - SAMPLE_W=12, LEVEL_W=4, LVL_MAX=15.
  - The FSM state encoding (ACCUM/MAP/UPDATE).
- The bar renderer uses LVL_MAX and LEVEL_W from `vol_pkg`.
- Sub-module `vol_map` is the combinational peak→raw-level mapper (OFFSET/SHIFT/saturation). It is reused by the MAP stage and by the testbench model.

## Test plan
- **Reset mid-window:** drop `rst_n` after 2 of 4 samples (WINDOW=4) → all outputs 0 immediately. The next window needs 4 fresh samples.
- **Basic window:** WINDOW=4, samples 2000, 3000, 2100, 2048 → `peak`=3000, `num`=7 (952>>7), `level_valid` pulse exactly 3 cycles after the 4th strobe.
- **Mapping edges:** WINDOW=1, samples spaced 5 cycles apart:
  - 1000 → 0
  - 2048 → 0
  - 2175 → 0
  - 2176 → 1
  - 4095 → 15
- **Hold/decay:** HOLD=2, one window at 4095 then quiet windows at 2048 → `num` sequence 15, 15, 15, 14, 13, …, 0, then stays at 0.
- **Freeze:** `num`=3, `freeze`=1 across a window with peak 4095 → `num` stays 3, `peak`=4095, `level_valid` pulses. After release, the next loud window gives `num`=15.
- **Sample during MAP:** strobe in cycle T+1 after a close → it counts as sample 1 of the next window, which closes after WINDOW−1 further strobes with the correct max.
